// File: rtl/keypad_entry_buffer_if.sv
// keypad_entry_buffer_if
//   Bundles the keypad-side inputs and the candidate-code outputs of
//   keypad_entry_buffer.
//   master : drives key_valid, key_code, lock_in; observes the digits/pulses.
//   slave  : the buffer itself; receives keys and drives d4..d1,
//            digit_count, entry_valid, entry_error, timeout.
interface keypad_entry_buffer_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       lock_in;
    logic [3:0] d4;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [2:0] digit_count;
    logic       entry_valid;
    logic       entry_error;
    logic       timeout;

    modport master (
        output key_valid, key_code, lock_in,
        input  d4, d3, d2, d1, digit_count, entry_valid, entry_error, timeout
    );

    modport slave (
        input  key_valid, key_code, lock_in,
        output d4, d3, d2, d1, digit_count, entry_valid, entry_error, timeout
    );
endinterface

// File: rtl/keypad_entry_buffer.sv
// keypad_entry_buffer
//   Assembles four BCD digits from keypad strobes into a candidate code
//   (d4 oldest, d1 newest) and commits it on the enter key.
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous, active-high reset
//     bus    : keypad_entry_buffer_if.slave
//              key_valid/key_code/lock_in in;
//              d4..d1, digit_count, entry_valid, entry_error, timeout out
//   Parameter TIMEOUT_CYCLES: idle cycles tolerated in a partial entry (>= 2).
module keypad_entry_buffer #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input logic                  clk,
    input logic                  reset,
    keypad_entry_buffer_if.slave bus
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [3:0]    d4, d3, d2, d1;
    logic [2:0]    digit_count;
    logic          entry_valid, entry_error, timeout;

    logic is_digit, is_clear, is_enter;

    always_comb begin
        is_digit = bus.key_valid && (bus.key_code <= 4'd9);
        is_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);
        is_enter = bus.key_valid && (bus.key_code == KEY_ENTER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            d4          <= '0;
            d3          <= '0;
            d2          <= '0;
            d1          <= '0;
            digit_count <= '0;
            entry_valid <= 1'b0;
            entry_error <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            entry_valid <= 1'b0;
            entry_error <= 1'b0;
            timeout     <= 1'b0;
            // Lockout freezes everything, timer included.
            if (!bus.lock_in) begin
                // A digit in FULL is not accepted: it falls through to the
                // timer branch, so it neither restarts nor stops the timer.
                if (is_digit && state != FULL) begin
                    timer <= '0;
                    if (state == DONE) begin
                        d4          <= '0;
                        d3          <= '0;
                        d2          <= '0;
                        d1          <= bus.key_code;
                        digit_count <= 3'd1;
                        state       <= ENTRY;
                    end else begin
                        d4          <= d3;
                        d3          <= d2;
                        d2          <= d1;
                        d1          <= bus.key_code;
                        digit_count <= digit_count + 3'd1;
                        state       <= (digit_count == 3'd3) ? FULL : ENTRY;
                    end
                end else if (is_clear) begin
                    timer       <= '0;
                    d4          <= '0;
                    d3          <= '0;
                    d2          <= '0;
                    d1          <= '0;
                    digit_count <= '0;
                    state       <= IDLE;
                end else if (is_enter && state != DONE) begin
                    timer <= '0;
                    if (state == FULL) begin
                        entry_valid <= 1'b1;
                        state       <= DONE;
                    end else begin
                        entry_error <= 1'b1;
                        d4          <= '0;
                        d3          <= '0;
                        d2          <= '0;
                        d1          <= '0;
                        digit_count <= '0;
                        state       <= IDLE;
                    end
                end else if (state == ENTRY || state == FULL) begin
                    if (timer == TIMER_LAST) begin
                        timeout     <= 1'b1;
                        timer       <= '0;
                        d4          <= '0;
                        d3          <= '0;
                        d2          <= '0;
                        d1          <= '0;
                        digit_count <= '0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end else begin
                    timer <= '0;
                end
            end
        end
    end

    assign bus.d4          = d4;
    assign bus.d3          = d3;
    assign bus.d2          = d2;
    assign bus.d1          = d1;
    assign bus.digit_count = digit_count;
    assign bus.entry_valid = entry_valid;
    assign bus.entry_error = entry_error;
    assign bus.timeout     = timeout;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// tb_keypad_entry_buffer
//   Scoreboard bench for keypad_entry_buffer with TIMEOUT_CYCLES = 8.
//   Each driven cycle pushes the predicted outputs; they are popped and
//   compared one clock later, plus directed checks on key milestones.
module tb_keypad_entry_buffer;

    localparam int T = 8;

    typedef struct packed {
        logic [15:0] digits;
        logic [2:0]  cnt;
        logic        ev;
        logic        er;
        logic        to;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    exp_t exp_q[$];

    // Reference model state (0 IDLE, 1 ENTRY, 2 FULL, 3 DONE)
    int          m_st;
    logic [15:0] m_code;
    int          m_cnt;
    int          m_timer;

    keypad_entry_buffer_if bus();

    keypad_entry_buffer #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] dut_digits();
        return {bus.d4, bus.d3, bus.d2, bus.d1};
    endfunction

    task automatic model_reset();
        m_st = 0; m_code = '0; m_cnt = 0; m_timer = 0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kc, input logic lk, output exp_t e);
        e = '0;
        if (!lk) begin
            if (kv && kc < 4'd10 && m_st != 2) begin
                if (m_st == 3) begin
                    m_code = {12'h000, kc};
                    m_cnt  = 1;
                end else begin
                    m_code = {m_code[11:0], kc};
                    m_cnt  = m_cnt + 1;
                end
                m_st    = (m_cnt == 4) ? 2 : 1;
                m_timer = 0;
            end else if (kv && kc == 4'hA) begin
                m_code = '0; m_cnt = 0; m_st = 0; m_timer = 0;
            end else if (kv && kc == 4'hB && m_st != 3) begin
                m_timer = 0;
                if (m_st == 2) begin
                    e.ev = 1'b1;
                    m_st = 3;
                end else begin
                    e.er = 1'b1;
                    m_code = '0; m_cnt = 0; m_st = 0;
                end
            end else if (m_st == 1 || m_st == 2) begin
                if (m_timer == T - 1) begin
                    e.to = 1'b1;
                    m_code = '0; m_cnt = 0; m_st = 0; m_timer = 0;
                end else begin
                    m_timer++;
                end
            end else begin
                m_timer = 0;
            end
        end
        e.digits = m_code;
        e.cnt    = 3'(m_cnt);
    endtask

    task automatic compare_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("digits",      32'(dut_digits()),      32'(e.digits));
            check("digit_count", 32'(bus.digit_count),   32'(e.cnt));
            check("entry_valid", 32'(bus.entry_valid),   32'(e.ev));
            check("entry_error", 32'(bus.entry_error),   32'(e.er));
            check("timeout",     32'(bus.timeout),       32'(e.to));
        end
    endtask

    task automatic step(input logic kv, input logic [3:0] kc, input logic lk);
        exp_t e;
        bus.key_valid = kv;
        bus.key_code  = kc;
        bus.lock_in   = lk;
        model_step(kv, kc, lk, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        compare_out();
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b1, kc, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.lock_in   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_digits", 32'(dut_digits()), 32'd0);
        check("reset_count",  32'(bus.digit_count), 32'd0);
        check("reset_pulses", 32'({bus.entry_valid, bus.entry_error, bus.timeout}), 32'd0);
        reset = 1'b0;

        // Full entry committed, then held in DONE
        key(4'd1); key(4'd2); key(4'd3); key(4'd4);
        key(4'hB);
        check("commit_digits", 32'(dut_digits()), 32'h1234);
        check("commit_valid",  32'(bus.entry_valid), 32'd1);
        idle(3);
        check("done_held",     32'(dut_digits()), 32'h1234);
        key(4'hB);
        check("done_enter_ignored", 32'(bus.entry_valid), 32'd0);

        // Short entry error
        key(4'hA);
        key(4'd5); key(4'd6); key(4'hB);
        check("short_error",  32'(bus.entry_error), 32'd1);
        check("short_digits", 32'(dut_digits()), 32'd0);

        // Fifth digit ignored, clear, fresh digit
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd7);
        check("fifth_ignored", 32'(dut_digits()), 32'h1234);
        key(4'hA);
        check("clear_digits", 32'(dut_digits()), 32'd0);
        key(4'd9);
        check("after_clear_d1", 32'({bus.digit_count, dut_digits()}), 32'h10009);
        key(4'hA);

        // Timeout after T cycles; an ignored code mid-way does not restart it
        key(4'd3);
        idle(2);
        step(1'b1, 4'hD, 1'b0);
        idle(T - 4);
        check("no_early_timeout", 32'(bus.timeout), 32'd0);
        idle(1);
        check("timeout_pulse",  32'(bus.timeout), 32'd1);
        check("timeout_digits", 32'(dut_digits()), 32'd0);

        // Key arriving on the expiring edge wins and restarts the timer
        key(4'd3);
        idle(T - 1);
        key(4'd5);
        check("key_beats_timeout", 32'({bus.timeout, bus.digit_count}), 32'd2);
        idle(T - 1);
        check("restart_no_timeout", 32'(bus.timeout), 32'd0);
        idle(1);
        check("restart_timeout", 32'(bus.timeout), 32'd1);

        // Lockout: keys ignored
        step(1'b1, 4'd1, 1'b1); step(1'b1, 4'd2, 1'b1); step(1'b1, 4'hB, 1'b1);
        check("lock_no_change", 32'({bus.digit_count, dut_digits()}), 32'd0);
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'hB);
        check("post_lock_valid", 32'(bus.entry_valid), 32'd1);
        key(4'hA);

        // Lockout freezes the timer
        key(4'd3);
        idle(4);
        for (int i = 0; i < 10; i++) step(1'b1, 4'd9, 1'b1);
        idle(3);
        check("frozen_no_timeout", 32'(bus.timeout), 32'd0);
        idle(1);
        check("frozen_timeout", 32'(bus.timeout), 32'd1);

        // DONE followed by a digit, then async reset mid-entry
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'hB);
        key(4'd8);
        check("done_digit", 32'({bus.digit_count, dut_digits()}), 32'h10008);
        key(4'd2);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_reset_digits", 32'(dut_digits()), 32'd0);
        check("async_reset_count",  32'(bus.digit_count), 32'd0);
        #3;
        reset = 1'b0;
        @(posedge clk);
        #1;
        key(4'd6);
        check("after_reset_entry", 32'({bus.digit_count, dut_digits()}), 32'h10006);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
